// File: rtl/butterfly_unit_if.sv
// Purpose: groups the request, sample/twiddle, multiplier handshake and result
//          signals of butterfly_unit. master = the butterfly side, slave = its
//          environment (request source, shared multiplier, result consumer).
// Ports:   start/a/b/w in; mul_enable/mul_A/mul_B out, mul_done/mul_product in;
//          y0/y1/valid/busy out (directions as seen from master).
interface butterfly_unit_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         start;
  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic signed [DATA_WIDTH-1:0] w_re, w_im;

  logic                         mul_enable;
  logic signed [DATA_WIDTH-1:0] mul_A, mul_B;
  logic                         mul_done;
  logic signed [DATA_WIDTH-1:0] mul_product;

  logic signed [DATA_WIDTH-1:0] y0_re, y0_im, y1_re, y1_im;
  logic                         valid;
  logic                         busy;

  modport master (
    input  start, a_re, a_im, b_re, b_im, w_re, w_im,
    output mul_enable, mul_A, mul_B,
    input  mul_done, mul_product,
    output y0_re, y0_im, y1_re, y1_im, valid, busy
  );

  modport slave (
    output start, a_re, a_im, b_re, b_im, w_re, w_im,
    input  mul_enable, mul_A, mul_B,
    output mul_done, mul_product,
    input  y0_re, y0_im, y1_re, y1_im, valid, busy
  );
endinterface

// File: rtl/butterfly_unit.sv
// Purpose: radix-2 DIT butterfly y0=a+w*b, y1=a-w*b using a shared external
//          multiplier for the four partial products; optional /2 and saturation.
// Latency: valid 4*(L+1)+1 cycles after the start edge (L = multiplier latency).
// Flow:    start is only taken in IDLE (no queuing); busy high while working.
// Ports:   clk, reset_n (async active-low), bus (butterfly_unit_if.master).
module butterfly_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int SCALE      = 1
) (
  input logic              clk,
  input logic              reset_n,
  butterfly_unit_if.master bus
);
  localparam int DW = DATA_WIDTH;
  localparam int W1 = DW + 1;
  localparam int W2 = DW + 2;
  localparam logic signed [W2-1:0] SAT_MAX = W2'((2 ** (DW - 1)) - 1);
  localparam logic signed [W2-1:0] SAT_MIN = W2'(-(2 ** (DW - 1)));

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMBINE, OUT} state_t;

  state_t               state;
  logic [1:0]           idx;
  logic signed [DW-1:0] a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
  logic signed [DW-1:0] p_q [4];
  logic                 mul_enable_q, valid_q, busy_q;
  logic signed [DW-1:0] mul_a_q, mul_b_q;
  logic signed [DW-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;

  // Product order: P0=w_re*b_re, P1=w_im*b_im, P2=w_re*b_im, P3=w_im*b_re.
  // Twiddle alternates re/im on idx[0]; sample is im for idx 1 and 2.
  logic [1:0]           idx_nxt;
  logic signed [DW-1:0] nxt_w, nxt_b;
  always_comb begin
    idx_nxt = idx + 2'd1;
    nxt_w   = idx_nxt[0] ? w_im_q : w_re_q;
    nxt_b   = (idx_nxt[0] ^ idx_nxt[1]) ? b_im_q : b_re_q;
  end

  // Full-precision combine: no wrap before the final scale/saturate.
  logic signed [W1-1:0] t_re, t_im;
  logic signed [W2-1:0] s0_re, s0_im, s1_re, s1_im;
  always_comb begin
    t_re  = W1'(p_q[0]) - W1'(p_q[1]);
    t_im  = W1'(p_q[2]) + W1'(p_q[3]);
    s0_re = W2'(a_re_q) + W2'(t_re);
    s0_im = W2'(a_im_q) + W2'(t_im);
    s1_re = W2'(a_re_q) - W2'(t_re);
    s1_im = W2'(a_im_q) - W2'(t_im);
  end

  // Arithmetic shift floors toward -inf, applied before clamping.
  function automatic logic signed [DW-1:0] scale_sat(input logic signed [W2-1:0] v);
    logic signed [W2-1:0] s;
    s = (SCALE != 0) ? (v >>> 1) : v;
    if (s > SAT_MAX) return SAT_MAX[DW-1:0];
    if (s < SAT_MIN) return SAT_MIN[DW-1:0];
    return s[DW-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= 2'd0;
      a_re_q       <= '0;
      a_im_q       <= '0;
      b_re_q       <= '0;
      b_im_q       <= '0;
      w_re_q       <= '0;
      w_im_q       <= '0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
      mul_enable_q <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      y0_re_q      <= '0;
      y0_im_q      <= '0;
      y1_re_q      <= '0;
      y1_im_q      <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_re_q       <= bus.a_re;
            a_im_q       <= bus.a_im;
            b_re_q       <= bus.b_re;
            b_im_q       <= bus.b_im;
            w_re_q       <= bus.w_re;
            w_im_q       <= bus.w_im;
            // First operands come straight from the inputs being latched.
            mul_a_q      <= bus.w_re;
            mul_b_q      <= bus.b_re;
            mul_enable_q <= 1'b1;
            idx          <= 2'd0;
            busy_q       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          mul_enable_q <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          if (bus.mul_done) begin
            p_q[idx] <= bus.mul_product;
            if (idx == 2'd3) begin
              state <= COMBINE;
            end else begin
              // Operands change only here, so they hold for the whole wait.
              idx          <= idx_nxt;
              mul_a_q      <= nxt_w;
              mul_b_q      <= nxt_b;
              mul_enable_q <= 1'b1;
              state        <= ISSUE;
            end
          end
        end
        COMBINE: begin
          y0_re_q <= scale_sat(s0_re);
          y0_im_q <= scale_sat(s0_im);
          y1_re_q <= scale_sat(s1_re);
          y1_im_q <= scale_sat(s1_im);
          valid_q <= 1'b1;
          idx     <= 2'd0;
          state   <= OUT;
        end
        OUT: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          mul_enable_q <= 1'b0;
          valid_q      <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.mul_enable = mul_enable_q;
  assign bus.mul_A      = mul_a_q;
  assign bus.mul_B      = mul_b_q;
  assign bus.y0_re      = y0_re_q;
  assign bus.y0_im      = y0_im_q;
  assign bus.y1_re      = y1_re_q;
  assign bus.y1_im      = y1_im_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_butterfly_unit.sv
// Purpose: checks butterfly_unit with SCALE=0 and SCALE=1 side by side against
//          a plain-arithmetic reference, with a latency-configurable multiplier.
// Ports:   none (top-level bench).
module tb_butterfly_unit;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic                 start;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic                 mul_done;
  logic signed [DW-1:0] prod0, prod1;

  butterfly_unit_if #(.DATA_WIDTH(DW)) bus0 ();
  butterfly_unit_if #(.DATA_WIDTH(DW)) bus1 ();

  butterfly_unit #(.DATA_WIDTH(DW), .SCALE(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.master));
  butterfly_unit #(.DATA_WIDTH(DW), .SCALE(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.master));

  assign bus0.start = start;  assign bus1.start = start;
  assign bus0.a_re  = a_re;   assign bus1.a_re  = a_re;
  assign bus0.a_im  = a_im;   assign bus1.a_im  = a_im;
  assign bus0.b_re  = b_re;   assign bus1.b_re  = b_re;
  assign bus0.b_im  = b_im;   assign bus1.b_im  = b_im;
  assign bus0.w_re  = w_re;   assign bus1.w_re  = w_re;
  assign bus0.w_im  = w_im;   assign bus1.w_im  = w_im;
  assign bus0.mul_done    = mul_done;
  assign bus1.mul_done    = mul_done;
  assign bus0.mul_product = prod0;
  assign bus1.mul_product = prod1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Q1.15 x Q10.5 -> Q10.5, truncated to the word width.
  function automatic int mulf(input int a, input int b);
    int p;
    p = (a * b) >>> 15;
    if (p > 32767) p -= 65536;
    return p;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic ref_bfly(input int ar, ai, br, bi, wr, wi, input int scale,
                          output int y0r, y0i, y1r, y1i);
    int tr, ti, s[4];
    tr = mulf(wr, br) - mulf(wi, bi);
    ti = mulf(wr, bi) + mulf(wi, br);
    s[0] = ar + tr; s[1] = ai + ti; s[2] = ar - tr; s[3] = ai - ti;
    for (int i = 0; i < 4; i++) begin
      if (scale != 0) s[i] = s[i] >>> 1;
      s[i] = sat16(s[i]);
    end
    y0r = s[0]; y0i = s[1]; y1r = s[2]; y1i = s[3];
  endtask

  // Event counters, sampled mid-cycle.
  int en_cnt0 = 0, en_cnt1 = 0, vld_cnt0 = 0, vld_cnt1 = 0;
  initial forever begin
    @(negedge clk);
    if (bus0.mul_enable) en_cnt0++;
    if (bus1.mul_enable) en_cnt1++;
    if (bus0.valid) vld_cnt0++;
    if (bus1.valid) vld_cnt1++;
  end

  // Shared multiplier model: operands sampled at the request, done pulse L
  // cycles later. A product is deliberately corrupted if the operands moved.
  int lat = 1;
  initial begin
    logic signed [DW-1:0] a0, b0, a1, b1;
    mul_done = 1'b0;
    prod0 = '0;
    prod1 = '0;
    forever begin
      @(negedge clk);
      if (bus0.mul_enable || bus1.mul_enable) begin
        a0 = bus0.mul_A; b0 = bus0.mul_B;
        a1 = bus1.mul_A; b1 = bus1.mul_B;
        repeat (lat) @(posedge clk);
        #1;
        prod0 = DW'(mulf(a0, b0));
        prod1 = DW'(mulf(a1, b1));
        if (bus0.mul_A !== a0 || bus0.mul_B !== b0) prod0 = ~prod0;
        if (bus1.mul_A !== a1 || bus1.mul_B !== b1) prod1 = ~prod1;
        mul_done = 1'b1;
        @(posedge clk);
        #1 mul_done = 1'b0;
      end
    end
  end

  task automatic chk_cleared(input string tag);
    chk({tag, "_y0re"}, bus0.y0_re, 0);
    chk({tag, "_y0im"}, bus0.y0_im, 0);
    chk({tag, "_y1re"}, bus0.y1_re, 0);
    chk({tag, "_y1im"}, bus0.y1_im, 0);
    chk({tag, "_busy"}, int'(bus0.busy), 0);
    chk({tag, "_valid"}, int'(bus0.valid), 0);
    chk({tag, "_mulen"}, int'(bus0.mul_enable), 0);
    chk({tag, "_mulA"}, bus0.mul_A, 0);
    chk({tag, "_mulB"}, bus0.mul_B, 0);
    chk({tag, "_s1_y0re"}, bus1.y0_re, 0);
    chk({tag, "_s1_y1im"}, bus1.y1_im, 0);
    chk({tag, "_s1_busy"}, int'(bus1.busy), 0);
  endtask

  // One full operation, including a start re-pulse while busy and a start
  // held during the OUT cycle, both of which must be ignored.
  task automatic do_op(input int ar, ai, br, bi, wr, wi, input int l, input string tag);
    int e0, e1, v0, v1, cyc;
    int r0[4], r1[4];
    lat = l;
    a_re = DW'(ar); a_im = DW'(ai); b_re = DW'(br); b_im = DW'(bi);
    w_re = DW'(wr); w_im = DW'(wi);
    e0 = en_cnt0; e1 = en_cnt1; v0 = vld_cnt0; v1 = vld_cnt1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Inputs are don't-care once latched.
    a_re = DW'($urandom); a_im = DW'($urandom); b_re = DW'($urandom);
    b_im = DW'($urandom); w_re = DW'($urandom); w_im = DW'($urandom);
    chk({tag, "_busy"}, int'(bus0.busy), 1);
    cyc = 0;
    while (!bus0.valid && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 3) start = 1'b1;
      if (cyc == 4) start = 1'b0;
    end
    chk({tag, "_vld_cyc"}, cyc, 4 * (l + 1) + 1);
    chk({tag, "_s1_valid"}, int'(bus1.valid), 1);
    ref_bfly(ar, ai, br, bi, wr, wi, 0, r0[0], r0[1], r0[2], r0[3]);
    ref_bfly(ar, ai, br, bi, wr, wi, 1, r1[0], r1[1], r1[2], r1[3]);
    chk({tag, "_y0re"}, bus0.y0_re, r0[0]);
    chk({tag, "_y0im"}, bus0.y0_im, r0[1]);
    chk({tag, "_y1re"}, bus0.y1_re, r0[2]);
    chk({tag, "_y1im"}, bus0.y1_im, r0[3]);
    chk({tag, "_s1_y0re"}, bus1.y0_re, r1[0]);
    chk({tag, "_s1_y0im"}, bus1.y0_im, r1[1]);
    chk({tag, "_s1_y1re"}, bus1.y1_re, r1[2]);
    chk({tag, "_s1_y1im"}, bus1.y1_im, r1[3]);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_out_valid"}, int'(bus0.valid), 0);
    chk({tag, "_out_busy"}, int'(bus0.busy), 0);
    chk({tag, "_out_s1_busy"}, int'(bus1.busy), 0);
    chk({tag, "_n_en"}, en_cnt0 - e0, 4);
    chk({tag, "_s1_n_en"}, en_cnt1 - e1, 4);
    chk({tag, "_n_vld"}, vld_cnt0 - v0, 1);
    chk({tag, "_s1_n_vld"}, vld_cnt1 - v1, 1);
  endtask

  initial begin
    int e0, v0, v1, k;
    reset_n = 1'b0;
    start = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    #1;
    chk_cleared("rst");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(100, -50, 64, 128, 16'h4000, 0, 1, "ex1");
    chk("ex1_lit_y0re", bus0.y0_re, 132);
    chk("ex1_lit_y1im", bus0.y1_im, -114);
    chk("ex1_lit_s1_y0im", bus1.y0_im, 7);
    chk("ex1_lit_s1_y1im", bus1.y1_im, -57);
    do_op(0, 0, 64, 128, 0, 16'h4000, 1, "ex2");
    chk("ex2_lit_y0re", bus0.y0_re, -64);
    chk("ex2_lit_y1im", bus0.y1_im, -32);
    do_op(32767, -32768, 32766, -32768, 16'h4000, 0, 1, "sat");
    chk("sat_lit_y0re", bus0.y0_re, 32767);
    chk("sat_lit_y0im", bus0.y0_im, -32768);
    chk("sat_lit_y1re", bus0.y1_re, 16384);
    do_op(100, -50, 64, 128, 16'h4000, 0, 3, "lat3");
    chk("lat3_lit_s1_y0re", bus1.y0_re, 66);
    chk("lat3_lit_s1_y1re", bus1.y1_re, 34);
    do_op(-32768, -32768, -32768, -32768, -32768, -32768, 2, "corner");

    // Abort in the wait for P2; nothing may come out of the aborted request.
    lat = 2;
    a_re = 16'sd1000; a_im = 16'sd2000; b_re = 16'sd300; b_im = -16'sd400;
    w_re = 16'sh2000; w_im = -16'sh3000;
    e0 = en_cnt0; v0 = vld_cnt0; v1 = vld_cnt1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while ((en_cnt0 - e0) < 3 && k < 50) begin
      @(posedge clk);
      k++;
    end
    chk("abort_reach_p2", en_cnt0 - e0, 3);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk_cleared("abort");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_vld", vld_cnt0 - v0, 0);
    chk("abort_s1_no_vld", vld_cnt1 - v1, 0);
    chk("abort_idle", int'(bus0.busy), 0);
    do_op(1000, 2000, 300, -400, 16'sh2000, -16'sh3000, 1, "post_abort");

    for (int i = 0; i < 20; i++) begin
      do_op(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
            int'($signed(16'($urandom))), int'($signed(16'($urandom))),
            int'($signed(16'($urandom))), int'($signed(16'($urandom))),
            int'($urandom_range(1, 4)), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/butterfly_unit.md
BUTTERFLY_UNIT -- requirements
Module: butterfly_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of every data, twiddle and product word.
REQ-002 SHALL have parameter SCALE, default 1: 1 = arithmetic shift right by 1 of both outputs (per-stage /2); 0 = no scaling.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 SHALL have ports a_re, a_im, b_re, b_im  input  DATA_WIDTH each  signed samples, Q10.5.
REQ-007 SHALL have ports w_re (cos), w_im (sin)  input  DATA_WIDTH each  signed twiddle, Q1.15.
REQ-008 SHALL have port mul_enable  output  1  one-cycle request pulse to the shared fixed-point multiplier.
REQ-009 SHALL have ports mul_A (twiddle, Q1.15), mul_B (sample, Q10.5)  output  DATA_WIDTH each  multiplier operands.
REQ-010 SHALL have ports mul_done  input  1 and mul_product  input  DATA_WIDTH: one-cycle completion pulse and product, Q10.5.
REQ-011 SHALL have ports y0_re, y0_im, y1_re, y1_im  output  DATA_WIDTH each  registered results, Q10.5.
REQ-012 SHALL have ports valid  output  1 (one-cycle result strobe) and busy  output  1 (high in every state except IDLE).

Function
REQ-013 SHALL latch all six inputs on the edge where start=1 in IDLE; inputs are don't-care afterwards.
REQ-014 SHALL sequence states IDLE -> ISSUE -> WAIT -> (ISSUE for next product | COMBINE) -> OUT -> IDLE.
REQ-015 SHALL compute four products in order P0=w_re*b_re, P1=w_im*b_im, P2=w_re*b_im, P3=w_im*b_re using a 2-bit product index.
REQ-016 SHALL assert mul_enable for exactly the one ISSUE cycle; mul_A/mul_B SHALL stay stable from ISSUE until mul_done is sampled.
REQ-017 SHALL, in WAIT, capture mul_product on the edge where mul_done=1, then go to ISSUE (index<3) or COMBINE (index=3).
REQ-018 SHALL ignore mul_done outside WAIT.
REQ-019 SHALL form t_re=P0-P1 and t_im=P2+P3 at DATA_WIDTH+1 bits, and y0=a+t, y1=a-t at DATA_WIDTH+2 bits, with no intermediate wrap.
REQ-020 SHALL, when SCALE=1, arithmetic-shift right by 1 (floor) before saturation.
REQ-021 SHALL saturate each output to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-022 SHALL register the outputs in COMBINE and pulse valid=1 for the single OUT cycle; outputs hold until the next OUT.
REQ-023 SHALL, with multiplier latency L (mul_done L>=1 cycles after mul_enable), raise valid exactly 4*(L+1)+1 cycles after the start edge.
REQ-024 SHALL ignore start while busy=1, with no queuing; start sampled in the OUT cycle is also ignored.
REQ-025 SHALL accept a new start the cycle after OUT (back-to-back operation).

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force IDLE, product index 0, busy=0, valid=0, mul_enable=0, mul_A=mul_B=0 and all y outputs 0.
REQ-027 SHALL, on reset mid-operation, discard all captured products; no valid is produced for the aborted request.

Verification
(Bench multiplier model: product=(A*B)>>>15, L=1 unless stated.)
REQ-028 SCALE=0, a=(100,-50), b=(64,128), w=(0x4000,0) -> valid at cycle 9; y0=(132,14); y1=(68,-114).
REQ-029 SCALE=0, a=(0,0), b=(64,128), w=(0,0x4000) -> y0=(-64,32); y1=(64,-32).
REQ-030 SCALE=0, a=(32767,-32768), b=(32766,-32768), w=(0x4000,0) -> y0=(32767,-32768) saturated; y1=(16384,-16384).
REQ-031 SCALE=1, inputs as REQ-028 -> y0=(66,7); y1=(34,-57); with L=3 -> valid 17 cycles after start, with exactly four mul_enable pulses.
REQ-032 start re-pulsed while busy -> ignored, one valid only; reset_n low during WAIT of P2 -> all outputs 0 immediately, no valid; a following start completes with the correct result.
